// File: rtl/pulse_stretcher.sv
// Stretches single-cycle trigger strobes into a level held for HOLD_TICKS
// timebase ticks, followed by an enforced low gap of GAP_TICKS ticks.
module pulse_stretcher #(
  parameter int HOLD_TICKS = 4,
  parameter int GAP_TICKS  = 2,
  parameter bit RETRIGGER  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic trig,
  output logic level_out,
  output logic busy,
  output logic overrun
);

  localparam int MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  // GAP_LAST is only consulted in GAP, which is unreachable when GAP_TICKS is 0.
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          pending;
  logic          pending_nxt;
  logic          overrun_nxt;

  // Next-state, counter, pending-flag and overrun decode.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    overrun_nxt = 1'b0;
    case (state)
      IDLE: begin
        pending_nxt = 1'b0;
        if (trig) begin
          state_nxt = HOLD;
          cnt_nxt   = CNT_ZERO;
        end else begin
          state_nxt = IDLE;
        end
      end

      HOLD: begin
        if (RETRIGGER && trig) begin
          // Retrigger beats a coincident final tick.
          cnt_nxt     = CNT_ZERO;
          pending_nxt = 1'b0;
        end else begin
          if (trig) begin
            if (pending) begin
              overrun_nxt = 1'b1;
            end else begin
              pending_nxt = 1'b1;
            end
          end else begin
            pending_nxt = pending;
          end
          if (tick) begin
            if (cnt == HOLD_LAST) begin
              cnt_nxt = CNT_ZERO;
              if (GAP_TICKS > 0) begin
                state_nxt = GAP;
              end else if (pending_nxt) begin
                state_nxt   = HOLD;
                pending_nxt = 1'b0;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end else begin
            cnt_nxt = cnt;
          end
        end
      end

      GAP: begin
        if (trig) begin
          if (pending) begin
            overrun_nxt = 1'b1;
          end else begin
            pending_nxt = 1'b1;
          end
        end else begin
          pending_nxt = pending;
        end
        if (tick) begin
          if (cnt == GAP_LAST) begin
            cnt_nxt = CNT_ZERO;
            if (pending_nxt) begin
              state_nxt   = HOLD;
              pending_nxt = 1'b0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else begin
          cnt_nxt = cnt;
        end
      end

      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = CNT_ZERO;
        pending_nxt = 1'b0;
      end
    endcase
  end

  // State register; outputs are decoded from the next state so they are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= CNT_ZERO;
      pending   <= 1'b0;
      level_out <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pending   <= pending_nxt;
      level_out <= (state_nxt == HOLD);
      busy      <= (state_nxt != IDLE);
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized and directed bench for pulse_stretcher: three configurations share
// one stimulus stream, each compared against a tick-countdown reference model.
module tb_pulse_stretcher;

  localparam int N = 3;
  int hcfg [N] = '{4, 4, 2};
  int gcfg [N] = '{2, 2, 0};
  bit rcfg [N] = '{1'b0, 1'b1, 1'b0};

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic tick    = 1'b0;
  logic trig    = 1'b0;
  logic lv [N];
  logic bz [N];
  logic ov [N];

  int hold_rem [N];
  int gap_rem  [N];
  bit q        [N];
  bit e_lv     [N];
  bit e_bz     [N];
  bit e_ov     [N];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(.HOLD_TICKS(4), .GAP_TICKS(2), .RETRIGGER(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .trig(trig),
    .level_out(lv[0]), .busy(bz[0]), .overrun(ov[0]));
  pulse_stretcher #(.HOLD_TICKS(4), .GAP_TICKS(2), .RETRIGGER(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .trig(trig),
    .level_out(lv[1]), .busy(bz[1]), .overrun(ov[1]));
  pulse_stretcher #(.HOLD_TICKS(2), .GAP_TICKS(0), .RETRIGGER(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .trig(trig),
    .level_out(lv[2]), .busy(bz[2]), .overrun(ov[2]));

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      hold_rem[d] = 0; gap_rem[d] = 0; q[d] = 1'b0;
      e_lv[d] = 1'b0; e_bz[d] = 1'b0; e_ov[d] = 1'b0;
    end
  endtask

  // Reference: remaining ticks of hold and gap, plus one queued trigger.
  task automatic model_step();
    for (int d = 0; d < N; d++) begin
      e_ov[d] = 1'b0;
      if (hold_rem[d] > 0) begin
        if (rcfg[d] && trig) begin
          hold_rem[d] = hcfg[d];
        end else begin
          if (trig) begin
            if (q[d]) e_ov[d] = 1'b1;
            else q[d] = 1'b1;
          end
          if (tick) begin
            hold_rem[d] = hold_rem[d] - 1;
            if (hold_rem[d] == 0) begin
              if (gcfg[d] > 0) gap_rem[d] = gcfg[d];
              else if (q[d]) begin hold_rem[d] = hcfg[d]; q[d] = 1'b0; end
            end
          end
        end
      end else if (gap_rem[d] > 0) begin
        if (trig) begin
          if (q[d]) e_ov[d] = 1'b1;
          else q[d] = 1'b1;
        end
        if (tick) begin
          gap_rem[d] = gap_rem[d] - 1;
          if (gap_rem[d] == 0 && q[d]) begin hold_rem[d] = hcfg[d]; q[d] = 1'b0; end
        end
      end else if (trig) begin
        hold_rem[d] = hcfg[d];
      end
      e_lv[d] = (hold_rem[d] > 0);
      e_bz[d] = (hold_rem[d] > 0) || (gap_rem[d] > 0);
    end
  endtask

  task automatic drive(input logic t, input logic k);
    trig = t;
    tick = k;
    @(posedge clk);
    model_step();
    #1;
    trig = 1'b0;
    tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    for (int d = 0; d < N; d++) begin
      n_checks++;
      if ({lv[d], bz[d], ov[d]} !== 3'b000)
        $display("FAIL reset dut%0d: lvl/busy/ovr=%b%b%b, required 000", d, lv[d], bz[d], ov[d]);
      else n_pass++;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int high_len = 0;
    apply_reset();
    for (int c = 0; c < 60; c++) begin
      drive(c == 10, (c % 4) == 3);
      for (int d = 0; d < N; d++) begin
        n_checks++;
        if ({lv[d], bz[d], ov[d]} !== {e_lv[d], e_bz[d], e_ov[d]})
          $display("FAIL single dut%0d cyc%0d: lvl/busy/ovr=%b%b%b, required %b%b%b",
                   d, c, lv[d], bz[d], ov[d], e_lv[d], e_bz[d], e_ov[d]);
        else n_pass++;
      end
      if (lv[0]) high_len++;
    end
    n_checks++;
    if (high_len < 13 || high_len > 16)
      $display("FAIL single_high_len: got %0d cycles, required 13..16", high_len);
    else n_pass++;
  endtask

  task automatic test_queued();
    int rises = 0, low_len = 0, ovr_cnt = 0, ovr_cyc = -1;
    logic prev = 1'b0;
    apply_reset();
    for (int c = 0; c < 80; c++) begin
      drive(c == 0 || c == 5 || c == 9, (c % 4) == 3);
      for (int d = 0; d < N; d++) begin
        n_checks++;
        if ({lv[d], bz[d], ov[d]} !== {e_lv[d], e_bz[d], e_ov[d]})
          $display("FAIL queued dut%0d cyc%0d: lvl/busy/ovr=%b%b%b, required %b%b%b",
                   d, c, lv[d], bz[d], ov[d], e_lv[d], e_bz[d], e_ov[d]);
        else n_pass++;
      end
      if (lv[0] && !prev) rises++;
      if (!lv[0] && rises == 1) low_len++;
      if (ov[0]) begin ovr_cnt++; ovr_cyc = c; end
      prev = lv[0];
    end
    n_checks++;
    if (rises != 2) $display("FAIL queued_pulses: got %0d, required 2", rises);
    else n_pass++;
    n_checks++;
    if (low_len != 8) $display("FAIL queued_gap: got %0d cycles low, required 8", low_len);
    else n_pass++;
    n_checks++;
    if (ovr_cnt != 1 || ovr_cyc != 9)
      $display("FAIL queued_overrun: got %0d pulses at cyc %0d, required 1 at cyc 9", ovr_cnt, ovr_cyc);
    else n_pass++;
  endtask

  task automatic test_retrig();
    int high_len = 0, ovr_cnt = 0;
    apply_reset();
    for (int c = 0; c < 60; c++) begin
      drive(c == 0 || c == 8, (c % 4) == 3);
      for (int d = 0; d < N; d++) begin
        n_checks++;
        if ({lv[d], bz[d], ov[d]} !== {e_lv[d], e_bz[d], e_ov[d]})
          $display("FAIL retrig dut%0d cyc%0d: lvl/busy/ovr=%b%b%b, required %b%b%b",
                   d, c, lv[d], bz[d], ov[d], e_lv[d], e_bz[d], e_ov[d]);
        else n_pass++;
      end
      if (lv[1]) high_len++;
      if (ov[1]) ovr_cnt++;
    end
    n_checks++;
    if (high_len != 23 || ovr_cnt != 0)
      $display("FAIL retrig_len: got %0d cycles high and %0d overruns, required 23 and 0", high_len, ovr_cnt);
    else n_pass++;
  endtask

  task automatic test_final_gap();
    int rises = 0, low_len = 0;
    bit fired = 1'b0;
    logic prev = 1'b0;
    logic t;
    logic k;
    apply_reset();
    for (int c = 0; c < 60; c++) begin
      k = ((c % 4) == 3);
      t = (c == 0) || (!fired && gap_rem[0] == 1 && k);
      if (c != 0 && t) fired = 1'b1;
      drive(t, k);
      for (int d = 0; d < N; d++) begin
        n_checks++;
        if ({lv[d], bz[d], ov[d]} !== {e_lv[d], e_bz[d], e_ov[d]})
          $display("FAIL final_gap dut%0d cyc%0d: lvl/busy/ovr=%b%b%b, required %b%b%b",
                   d, c, lv[d], bz[d], ov[d], e_lv[d], e_bz[d], e_ov[d]);
        else n_pass++;
      end
      if (lv[0] && !prev) rises++;
      if (!lv[0] && rises == 1) low_len++;
      prev = lv[0];
    end
    n_checks++;
    if (!fired || rises != 2 || low_len != 8)
      $display("FAIL final_gap_low: got fired=%0d rises=%0d low=%0d, required 1, 2, 8", fired, rises, low_len);
    else n_pass++;
  endtask

  task automatic test_merge();
    int high_len = 0, rises = 0;
    logic prev = 1'b0;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      drive(c == 5 || c == 6, 1'b1);
      for (int d = 0; d < N; d++) begin
        n_checks++;
        if ({lv[d], bz[d], ov[d]} !== {e_lv[d], e_bz[d], e_ov[d]})
          $display("FAIL merge dut%0d cyc%0d: lvl/busy/ovr=%b%b%b, required %b%b%b",
                   d, c, lv[d], bz[d], ov[d], e_lv[d], e_bz[d], e_ov[d]);
        else n_pass++;
      end
      if (lv[2]) high_len++;
      if (lv[2] && !prev) rises++;
      prev = lv[2];
    end
    n_checks++;
    if (high_len != 4 || rises != 1)
      $display("FAIL merge_len: got %0d cycles high in %0d pulses, required 4 in 1", high_len, rises);
    else n_pass++;
  endtask

  task automatic test_late_reset();
    int rises = 0;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      drive(c == 5 || c == 6, 1'b1);
      for (int d = 0; d < N; d++) begin
        n_checks++;
        if ({lv[d], bz[d], ov[d]} !== {e_lv[d], e_bz[d], e_ov[d]})
          $display("FAIL late_reset dut%0d cyc%0d: lvl/busy/ovr=%b%b%b, required %b%b%b",
                   d, c, lv[d], bz[d], ov[d], e_lv[d], e_bz[d], e_ov[d]);
        else n_pass++;
      end
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < N; d++) begin
      n_checks++;
      if ({lv[d], bz[d], ov[d]} !== 3'b000)
        $display("FAIL late_reset_async dut%0d: lvl/busy/ovr=%b%b%b, required 000", d, lv[d], bz[d], ov[d]);
      else n_pass++;
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      drive(1'b0, 1'b1);
      for (int d = 0; d < N; d++) begin
        n_checks++;
        if ({lv[d], bz[d], ov[d]} !== {e_lv[d], e_bz[d], e_ov[d]})
          $display("FAIL post_reset dut%0d cyc%0d: lvl/busy/ovr=%b%b%b, required %b%b%b",
                   d, c, lv[d], bz[d], ov[d], e_lv[d], e_bz[d], e_ov[d]);
        else n_pass++;
        if (lv[d]) rises++;
      end
    end
    n_checks++;
    if (rises != 0) $display("FAIL post_reset_quiet: got %0d high samples, required 0", rises);
    else n_pass++;
  endtask

  task automatic test_random();
    int per = 1;
    int ph = 0;
    logic t;
    logic k;
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      if ((c % 100) == 0) begin
        per = $urandom_range(1, 5);
        ph = 0;
      end
      k = (ph == per - 1);
      ph = (ph == per - 1) ? 0 : ph + 1;
      t = ($urandom_range(0, 5) == 0);
      drive(t, k);
      for (int d = 0; d < N; d++) begin
        n_checks++;
        if ({lv[d], bz[d], ov[d]} !== {e_lv[d], e_bz[d], e_ov[d]})
          $display("FAIL random dut%0d cyc%0d: lvl/busy/ovr=%b%b%b, required %b%b%b",
                   d, c, lv[d], bz[d], ov[d], e_lv[d], e_bz[d], e_ov[d]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queued();
    test_retrig();
    test_final_gap();
    test_merge();
    test_late_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle event strobes into a held level output: each accepted trigger drives `level_out` high for `HOLD_TICKS` timebase ticks, followed by an enforced low gap of `GAP_TICKS` ticks. This is the reverse of edge detection, which turns a level into a pulse. The block sits downstream of the button edge detector, driving LEDs or a slow external line. Its `tick` input comes from the shared terminal-count timer, so durations scale with the timer period.

## Interface
- `HOLD_TICKS`, default 4: high duration in ticks; must be ≥1.
- `GAP_TICKS`, default 2: minimum low time between pulses in ticks; may be 0.
- `RETRIGGER`, default 0:
  - 1: a trigger during HOLD restarts the hold count.
  - 0: a trigger during HOLD is queued.
- `clk` in 1: clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: single-cycle timebase strobe.
- `trig` in 1: single-cycle event strobe.
- `level_out` out 1: stretched output, registered.
- `busy` out 1: high in HOLD or GAP, registered.
- `overrun` out 1: single-cycle pulse when a trigger is dropped, registered.

## Operation
- State: FSM {IDLE, HOLD, GAP}, tick counter `cnt`, 1-bit `pending` flag.
  - `cnt` width is `$clog2(max(HOLD_TICKS,GAP_TICKS)+1)`; it is never compared past its terminal value.
- IDLE: `level_out`=0, `busy`=0; `tick` is ignored.
  - `trig` → HOLD, `cnt`=0.
- HOLD: `level_out`=1, `busy`=1.
  - `tick` with `cnt`<`HOLD_TICKS`-1: `cnt`++.
  - `tick` with `cnt`=`HOLD_TICKS`-1 ends the hold; `cnt`=0. Next state:
    - GAP if `GAP_TICKS`>0;
    - else HOLD again (clearing `pending`) if `pending`=1;
    - else IDLE.
  - `trig` with `RETRIGGER`=1: `cnt`=0, stay in HOLD; `pending` is unused.
  - `trig` with `RETRIGGER`=0:
    - `pending`=0 → set `pending`;
    - `pending`=1 → pulse `overrun`, trigger lost.
- GAP: `level_out`=0, `busy`=1.
  - `tick` with `cnt`<`GAP_TICKS`-1: `cnt`++.
  - `tick` with `cnt`=`GAP_TICKS`-1: go to HOLD (`cnt`=0, clear `pending`) if `pending`=1, else IDLE.
  - `trig` in GAP follows the same pending/overrun rule as HOLD with `RETRIGGER`=0, regardless of the `RETRIGGER` setting.
- Simultaneous events:
  - `trig` + `tick` on entry cycle from IDLE: the tick is not counted.
  - `trig` + final HOLD tick, `RETRIGGER`=1: retrigger wins; stay in HOLD with `cnt`=0.
  - `trig` + final HOLD tick, `RETRIGGER`=0: the trigger is queued first, then the transition is evaluated with `pending`=1.
  - `trig` + final GAP tick: treated as pending; go directly to HOLD.
- `GAP_TICKS`=0 with a pending trigger: consecutive holds merge, and `level_out` stays high without a dropout.
- `overrun` is high exactly one cycle per dropped trigger and is never asserted in IDLE.

## Timing
- Reset (async assert, sync-released flops): state=IDLE, `cnt`=0, `pending`=0.
  - `level_out`=0, `busy`=0, `overrun`=0, all immediately on assertion.
- Reset mid-HOLD or mid-GAP: the output drops immediately; the queued trigger is discarded.
- Latency: `trig` sampled at edge k → `level_out` and `busy` are high from edge k onward (one-cycle registered latency).
- `level_out` falls at the edge that samples the `HOLD_TICKS`-th counted tick after HOLD entry.
- `busy` falls at the edge that samples the `GAP_TICKS`-th counted tick in GAP.
- With a tick every P clocks, high time is between (`HOLD_TICKS`-1)·P+1 and `HOLD_TICKS`·P cycles.
- `overrun` asserts the cycle after the offending `trig` edge.
- No combinational path from inputs to outputs.

## Test plan
- Single trigger: `HOLD_TICKS`=4, `GAP_TICKS`=2, `RETRIGGER`=0, tick every 4 clks; `trig` at cycle 10.
  - `level_out` rises at 11 and falls on the 4th tick edge after entry.
  - `busy` stays high for 2 more ticks, then returns to IDLE.
- Queued trigger and overrun: same config; `trig` during HOLD, then another `trig` during the same HOLD.
  - Exactly 2 pulses, separated by exactly 2 ticks low.
  - One `overrun` pulse, one cycle after the third `trig`.
- Retrigger: `RETRIGGER`=1; `trig` after the 2nd hold tick.
  - `level_out` stays high for 6 ticks total; `overrun` never asserts.
- Trigger on final GAP tick: `trig` coincident with the final GAP tick.
  - HOLD is entered at the next edge; the low gap is exactly `GAP_TICKS` ticks.
- Merged holds and late reset: `GAP_TICKS`=0, `HOLD_TICKS`=2, tick every clk; `trig` at cycles 5 and 6.
  - `level_out` is high continuously for 4 ticks.
  - Repeat with `reset_n` low at cycle 7: `level_out` and `busy` are 0 immediately, and no pulse follows reset release.
